// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between the requesters, the round-robin arbiter and the FIFO write port.
// The arbiter connects through the slave modport; the requester/FIFO side uses master.
interface fifo_wr_arbiter_if #(
   parameter int D_SIZE = 16,
   parameter int N_REQ  = 4
);
   logic [N_REQ-1:0]        i_req_valid;
   logic [N_REQ*D_SIZE-1:0] i_req_data;
   logic [N_REQ-1:0]        o_req_ready;
   logic [N_REQ-1:0]        o_grant;
   logic                    o_w_inc;
   logic [D_SIZE-1:0]       o_w_data;
   logic                    i_full;
   logic                    o_busy;

   modport slave (
      input  i_req_valid,
      input  i_req_data,
      input  i_full,
      output o_req_ready,
      output o_grant,
      output o_w_inc,
      output o_w_data,
      output o_busy
   );

   modport master (
      output i_req_valid,
      output i_req_data,
      output i_full,
      input  o_req_ready,
      input  o_grant,
      input  o_w_inc,
      input  o_w_data,
      input  o_busy
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FIFO write port among N_REQ requesters, with the grant
// held for at most MAX_BURST words (or until the holder goes idle) before rotating.

module fifo_wr_arbiter_chk #(
   parameter int D_SIZE = 16,
   parameter int N_REQ  = 4
) (
   input logic              clk,
   input logic              rst,
   input logic [N_REQ-1:0]  req_ready,
   input logic [N_REQ-1:0]  grant,
   input logic              w_inc,
   input logic [D_SIZE-1:0] w_data,
   input logic              full,
   input logic              busy
);
   ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
   grant_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(grant));
   inc_is_ready: assert property (@(posedge clk) disable iff (rst) w_inc == (|req_ready));
   busy_is_grant: assert property (@(posedge clk) disable iff (rst) busy == (|grant));
   no_write_full: assert property (@(posedge clk) disable iff (rst) full |-> !w_inc);
   idle_data_zero: assert property (@(posedge clk) disable iff (rst) !busy |-> (w_data == {D_SIZE{1'b0}}));
endmodule

module fifo_wr_arbiter #(
   parameter int D_SIZE    = 16,
   parameter int N_REQ     = 4,
   parameter int MAX_BURST = 4
) (
   input logic             w_clk,
   input logic             i_w_rst,
   fifo_wr_arbiter_if.slave arb
);
   localparam int IDX_W = $clog2(N_REQ);
   localparam int CNT_W = $clog2(MAX_BURST + 1);
   localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_REQ - 1);

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
      logic [IDX_W-1:0] nxt;
      nxt = (idx == IDX_LAST) ? {IDX_W{1'b0}} : IDX_W'(idx + IDX_W'(1));
      return nxt;
   endfunction

   // First valid index searching start, start+1, ... modulo N_REQ; MSB flags a winner.
   function automatic logic [IDX_W:0] rr_pick(input logic [N_REQ-1:0] valid,
                                              input logic [IDX_W-1:0] start);
      logic             found;
      logic [IDX_W-1:0] win;
      logic [IDX_W-1:0] idx;
      found = 1'b0;
      win   = start;
      idx   = start;
      for (int i = 0; i < N_REQ; i++) begin
         win   = (!found && valid[idx]) ? idx : win;
         found = found | valid[idx];
         idx   = idx_inc(idx);
      end
      return {found, win};
   endfunction

   function automatic logic [N_REQ-1:0] to_onehot(input logic [IDX_W-1:0] idx);
      return {{(N_REQ-1){1'b0}}, 1'b1} << idx;
   endfunction

   state_t            state_r, state_s;
   logic [N_REQ-1:0]  grant_r, grant_s;
   logic [IDX_W-1:0]  gidx_r, gidx_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [IDX_W-1:0]  rr_r, rr_s;

   logic              valid_g_s;
   logic [D_SIZE-1:0] data_g_s;
   logic              xfer_s;
   logic              release_s;
   logic [IDX_W-1:0]  start_s;
   logic [IDX_W:0]    pick_s;

   // Granted requester's view, write strobe, release condition and arbitration winner.
   always_comb begin
      valid_g_s = arb.i_req_valid[gidx_r];
      data_g_s  = arb.i_req_data[int'(gidx_r)*D_SIZE +: D_SIZE];
      xfer_s    = (state_r == ST_GRANT) && valid_g_s && !arb.i_full;
      release_s = (state_r == ST_GRANT) &&
                  ((xfer_s && (cnt_r == BURST_LAST)) || !valid_g_s);
      // After a release the search starts past the old holder, so it re-wins only when alone.
      start_s   = (state_r == ST_GRANT) ? idx_inc(gidx_r) : rr_r;
      pick_s    = rr_pick(arb.i_req_valid, start_s);
   end

   // Next-state logic for the IDLE/GRANT controller, grant, burst count and rr pointer.
   always_comb begin
      state_s = state_r;
      grant_s = grant_r;
      gidx_s  = gidx_r;
      cnt_s   = cnt_r;
      rr_s    = rr_r;
      case (state_r)
         ST_IDLE: begin
            if (pick_s[IDX_W]) begin
               state_s = ST_GRANT;
               gidx_s  = pick_s[IDX_W-1:0];
               grant_s = to_onehot(pick_s[IDX_W-1:0]);
               cnt_s   = {CNT_W{1'b0}};
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_GRANT: begin
            if (release_s) begin
               rr_s  = idx_inc(gidx_r);
               cnt_s = {CNT_W{1'b0}};
               if (pick_s[IDX_W]) begin
                  state_s = ST_GRANT;
                  gidx_s  = pick_s[IDX_W-1:0];
                  grant_s = to_onehot(pick_s[IDX_W-1:0]);
               end else begin
                  state_s = ST_IDLE;
                  grant_s = {N_REQ{1'b0}};
               end
            end else if (xfer_s) begin
               cnt_s = CNT_W'(cnt_r + CNT_W'(1));
            end else begin
               cnt_s = cnt_r;
            end
         end
         default: begin
            state_s = ST_IDLE;
            grant_s = {N_REQ{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // Controller state register with asynchronous reset.
   always_ff @(posedge w_clk or posedge i_w_rst) begin
      if (i_w_rst) begin
         state_r <= ST_IDLE;
         grant_r <= {N_REQ{1'b0}};
         gidx_r  <= {IDX_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         rr_r    <= {IDX_W{1'b0}};
      end else begin
         state_r <= state_s;
         grant_r <= grant_s;
         gidx_r  <= gidx_s;
         cnt_r   <= cnt_s;
         rr_r    <= rr_s;
      end
   end

   assign arb.o_grant     = grant_r;
   assign arb.o_busy      = (state_r == ST_GRANT);
   assign arb.o_w_inc     = xfer_s;
   assign arb.o_req_ready = grant_r & {N_REQ{xfer_s}};
   assign arb.o_w_data    = (state_r == ST_GRANT) ? data_g_s : {D_SIZE{1'b0}};

   fifo_wr_arbiter_chk #(
      .D_SIZE(D_SIZE),
      .N_REQ (N_REQ)
   ) u_chk (
      .clk      (w_clk),
      .rst      (i_w_rst),
      .req_ready(arb.o_req_ready),
      .grant    (arb.o_grant),
      .w_inc    (arb.o_w_inc),
      .w_data   (arb.o_w_data),
      .full     (arb.i_full),
      .busy     (arb.o_busy)
   );
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: inputs change on the falling edge, outputs are checked
// 1 ns later, before the rising edge that acts on them.
module tb_fifo_wr_arbiter;
   localparam int D_SIZE    = 16;
   localparam int N_REQ     = 4;
   localparam int MAX_BURST = 4;

   logic w_clk   = 1'b0;
   logic i_w_rst = 1'b1;
   int   checks  = 0;
   int   errors  = 0;
   int   served [N_REQ];
   int   g;

   fifo_wr_arbiter_if #(.D_SIZE(D_SIZE), .N_REQ(N_REQ)) bus ();

   fifo_wr_arbiter #(
      .D_SIZE   (D_SIZE),
      .N_REQ    (N_REQ),
      .MAX_BURST(MAX_BURST)
   ) dut (
      .w_clk  (w_clk),
      .i_w_rst(i_w_rst),
      .arb    (bus.slave)
   );

   always #5 w_clk = ~w_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic expect_cycle(input string tag, input logic [3:0] exp_grant,
                               input logic exp_inc, input logic [15:0] exp_data);
      chk({tag, "_grant"}, 32'(bus.o_grant), 32'(exp_grant));
      chk({tag, "_inc"},   32'(bus.o_w_inc), 32'(exp_inc));
      chk({tag, "_ready"}, 32'(bus.o_req_ready), 32'(exp_inc ? exp_grant : 4'b0000));
      chk({tag, "_busy"},  32'(bus.o_busy), 32'(|exp_grant));
      chk({tag, "_data"},  32'(bus.o_w_data), 32'(exp_data));
   endtask

   task automatic set_data(input int k, input logic [15:0] v);
      bus.i_req_data[k*D_SIZE +: D_SIZE] = v;
   endtask

   initial begin
      bus.i_req_valid = 4'b0000;
      bus.i_req_data  = {(N_REQ*D_SIZE){1'b0}};
      bus.i_full      = 1'b0;
      for (int k = 0; k < N_REQ; k++) served[k] = 0;

      // Reset state
      repeat (2) @(negedge w_clk);
      #1 expect_cycle("reset", 4'b0000, 1'b0, 16'h0000);
      @(negedge w_clk);
      i_w_rst = 1'b0;

      // Single requester 0: one-cycle grant latency, four words, then IDLE
      @(negedge w_clk);
      bus.i_req_valid = 4'b0001;
      set_data(0, 16'hA000);
      #1 expect_cycle("t1_idle", 4'b0000, 1'b0, 16'h0000);
      for (int w = 0; w < 4; w++) begin
         @(negedge w_clk);
         set_data(0, 16'(16'hA000 + w));
         #1 expect_cycle("t1_word", 4'b0001, 1'b1, 16'(16'hA000 + w));
      end
      @(negedge w_clk);
      bus.i_req_valid = 4'b0000;
      #1 expect_cycle("t1_drop", 4'b0001, 1'b0, 16'hA003);
      @(negedge w_clk);
      #1 expect_cycle("t1_after", 4'b0000, 1'b0, 16'h0000);

      // All valid from rr=1: order 1,2,3,0 with four back-to-back words each
      @(negedge w_clk);
      bus.i_req_valid = 4'b1111;
      for (int k = 0; k < N_REQ; k++) set_data(k, 16'(16'hB000 | k));
      #1 expect_cycle("t2_arb", 4'b0000, 1'b0, 16'h0000);
      for (int n = 0; n < 16; n++) begin
         @(negedge w_clk);
         #1;
         g = (1 + n / 4) % 4;
         expect_cycle("t2_rr", 4'(4'b0001 << g), 1'b1, 16'(16'hB000 | g));
         for (int k = 0; k < N_REQ; k++) served[k] += int'(bus.o_req_ready[k]);
      end
      for (int k = 0; k < N_REQ; k++) chk("t2_served", 32'(served[k]), 32'd4);
      @(negedge w_clk);
      #1 expect_cycle("t2_wrap", 4'b0010, 1'b1, 16'hB001);

      // Requester 2 stalled by full for 5 cycles after its second word
      @(negedge w_clk);
      bus.i_req_valid = 4'b0100;
      set_data(2, 16'hC000);
      #1 expect_cycle("t3_release", 4'b0010, 1'b0, 16'hB001);
      for (int w = 0; w < 2; w++) begin
         @(negedge w_clk);
         set_data(2, 16'(16'hC000 + w));
         #1 expect_cycle("t3_word", 4'b0100, 1'b1, 16'(16'hC000 + w));
      end
      @(negedge w_clk);
      set_data(2, 16'hC002);
      set_data(0, 16'hD000);
      bus.i_req_valid = 4'b0101;
      bus.i_full      = 1'b1;
      #1 expect_cycle("t3_stall", 4'b0100, 1'b0, 16'hC002);
      repeat (4) begin
         @(negedge w_clk);
         #1 expect_cycle("t3_stall", 4'b0100, 1'b0, 16'hC002);
      end
      @(negedge w_clk);
      bus.i_full = 1'b0;
      #1 expect_cycle("t3_resume", 4'b0100, 1'b1, 16'hC002);
      @(negedge w_clk);
      set_data(2, 16'hC003);
      #1 expect_cycle("t3_last", 4'b0100, 1'b1, 16'hC003);
      @(negedge w_clk);
      bus.i_req_valid = 4'b0001;
      #1 expect_cycle("t3_next", 4'b0001, 1'b1, 16'hD000);

      // Requester 1 drops valid after one word; 3 takes over with a fresh count
      @(negedge w_clk);
      bus.i_req_valid = 4'b1010;
      set_data(1, 16'hE100);
      set_data(3, 16'hE300);
      #1 expect_cycle("t4_release", 4'b0001, 1'b0, 16'hD000);
      @(negedge w_clk);
      #1 expect_cycle("t4_g1", 4'b0010, 1'b1, 16'hE100);
      @(negedge w_clk);
      bus.i_req_valid = 4'b1000;
      #1 expect_cycle("t4_drop", 4'b0010, 1'b0, 16'hE100);
      @(negedge w_clk);
      bus.i_req_valid = 4'b1010;
      #1 expect_cycle("t4_g3", 4'b1000, 1'b1, 16'hE300);
      repeat (3) begin
         @(negedge w_clk);
         #1 expect_cycle("t4_g3", 4'b1000, 1'b1, 16'hE300);
      end
      @(negedge w_clk);
      #1 expect_cycle("t4_back1", 4'b0010, 1'b1, 16'hE100);

      // Sole requester 0: re-granted across bursts with no bubble
      @(negedge w_clk);
      bus.i_req_valid = 4'b0001;
      set_data(0, 16'hF000);
      #1 expect_cycle("t5_release", 4'b0010, 1'b0, 16'hE100);
      repeat (10) begin
         @(negedge w_clk);
         #1 expect_cycle("t5_solo", 4'b0001, 1'b1, 16'hF000);
      end

      // Reset mid-burst clears outputs at once; arbitration restarts from index 0
      @(negedge w_clk);
      i_w_rst = 1'b1;
      #1 expect_cycle("t6_reset", 4'b0000, 1'b0, 16'h0000);
      @(negedge w_clk);
      i_w_rst = 1'b0;
      bus.i_req_valid = 4'b1111;
      for (int k = 0; k < N_REQ; k++) set_data(k, 16'(16'h5000 + k));
      #1 expect_cycle("t6_idle", 4'b0000, 1'b0, 16'h0000);
      @(negedge w_clk);
      #1 expect_cycle("t6_restart", 4'b0001, 1'b1, 16'h5000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
